ap_cmd_builder: RTL and testbench

- Upstream neighbour of the AHB access point, in the AFT_CLK domain.
- Accepts 35-bit access-port requests captured by the JTAG TAP on Update-DR, decodes them against a local CSW config register, and builds the 41-bit AP command word.
- Buffers command words in a small synchronous FIFO, which the AP drains through the rdata_fifo1/rempty/rinc interface.
- Reports WAIT/overflow/fault status back to the TAP capture path.

---
 rtl/ap_cmd_builder_if.sv | 22 ++
 rtl/ap_cmd_builder.sv | 78 +++++++
 tb/tb_ap_cmd_builder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ap_cmd_builder_if.sv
// ap_cmd_builder_if: TAP request, AP FIFO drain and status signals of the AP command builder.
interface ap_cmd_builder_if #(parameter int DEPTH = 4) ();
  localparam int PTR_W = $clog2(DEPTH);
  logic             upd_valid;
  logic [34:0]      upd_data;
  logic             sticky_clr;
  logic [40:0]      rdata_fifo1;
  logic             rempty;
  logic             rinc;
  logic             ack_wait;
  logic             sticky_ovf;
  logic             sticky_err;
  logic [PTR_W:0]   level;
  modport master (
    output upd_valid, upd_data, sticky_clr, rinc,
    input  rdata_fifo1, rempty, ack_wait, sticky_ovf, sticky_err, level
  );
  modport slave (
    input  upd_valid, upd_data, sticky_clr, rinc,
    output rdata_fifo1, rempty, ack_wait, sticky_ovf, sticky_err, level
  );
endinterface

// File: rtl/ap_cmd_builder.sv
// ap_cmd_builder: decodes TAP AP requests against a local CSW and queues AP command words in a FWFT FIFO.
module ap_cmd_builder #(
  parameter int DEPTH = 4
) (
  input logic              AFT_CLK,
  input logic              RST,
  ap_cmd_builder_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, DECODE, PUSH} state_t;
  state_t             state;
  logic [34:0]        req_reg;
  logic [40:0]        word;
  logic [1:0]         csw_size;
  logic [4:0]         csw_inc;
  logic [40:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wptr, rptr;
  logic [PTR_W:0]     lvl;
  logic               ovf, err;
  logic               full, empty, pop, push, ovf_set, err_set;
  always_comb begin
    full    = lvl == (PTR_W+1)'(DEPTH);
    empty   = lvl == '0;
    pop     = bus.rinc && !empty;
    // a pop on the same edge frees a slot, so a push into a full FIFO still lands
    push    = state == PUSH && (!full || pop);
    ovf_set = (state == PUSH && full && !pop) || (bus.upd_valid && state != IDLE);
    err_set = (state == DECODE && req_reg[2:1] == 2'b10) || (bus.rinc && empty);
  end
  assign bus.rdata_fifo1 = mem[rptr];
  assign bus.rempty      = empty;
  assign bus.level       = lvl;
  assign bus.ack_wait    = full || state != IDLE;
  assign bus.sticky_ovf  = ovf;
  assign bus.sticky_err  = err;
  always_ff @(posedge AFT_CLK) begin
    if (RST) begin
      state    <= IDLE;
      req_reg  <= '0;
      word     <= '0;
      csw_size <= 2'b10;
      csw_inc  <= '0;
      wptr     <= '0;
      rptr     <= '0;
      lvl      <= '0;
      ovf      <= 1'b0;
      err      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ovf <= (ovf && !bus.sticky_clr) || ovf_set;
      err <= (err && !bus.sticky_clr) || err_set;
      if (push) begin
        mem[wptr] <= word;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      lvl <= lvl + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      case (state)
        IDLE: begin
          if (bus.upd_valid) begin
            req_reg <= bus.upd_data;
            state   <= DECODE;
          end
        end
        DECODE: begin
          // A[1] doubles as reg_select, A[0] marks the pushing registers (TAR, DRW)
          word  <= {req_reg[34:3], req_reg[2], csw_size, csw_inc, ~req_reg[0]};
          state <= req_reg[1] ? PUSH : IDLE;
          if (req_reg[2:0] == 3'b000) begin
            csw_size <= req_reg[4:3];
            csw_inc  <= req_reg[15:11];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ap_cmd_builder.sv
// tb_ap_cmd_builder: table vectors, directed corner sequences and random traffic against a scheduled-event model.
module tb_ap_cmd_builder;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ap_cmd_builder_if #(.DEPTH(DEPTH)) bus ();
  ap_cmd_builder #(.DEPTH(DEPTH)) dut (.AFT_CLK(clk), .RST(rst), .bus(bus));
  typedef struct {
    logic [31:0] d;
    logic [1:0]  a;
    logic        rnw;
    logic [40:0] w;
    int          lvl;
  } vec_t;
  vec_t vt [8];
  int errs = 0;
  int checks = 0;
  logic [40:0] q [$];
  logic [1:0]  m_size;
  logic [4:0]  m_inc;
  logic        m_ovf, m_err;
  logic [40:0] m_word;
  int cyc = 0;
  int last_busy, push_at, err_at;
  function automatic logic [34:0] req(logic [31:0] d, logic [1:0] a, logic rnw);
    return {d, a, rnw};
  endfunction
  task automatic chk(string n, logic [40:0] act, logic [40:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_size = 2'b10;
    m_inc = 5'd0;
    m_ovf = 1'b0;
    m_err = 1'b0;
    last_busy = -1;
    push_at = -1;
    err_at = -1;
  endtask
  // Requests are modelled as scheduled events: accepted at edge e, CSW/error resolve at e+1, pushes land at e+2.
  task automatic model_edge(logic v, logic [34:0] r, logic clr, logic inc);
    logic so, se, pop;
    logic [31:0] data;
    logic [1:0] a;
    logic rnw;
    so = 1'b0;
    se = 1'b0;
    data = r[34:3];
    a = r[2:1];
    rnw = r[0];
    pop = inc && q.size() > 0;
    if (inc && q.size() == 0) se = 1'b1;
    if (pop) void'(q.pop_front());
    if (push_at == cyc) begin
      if (q.size() < DEPTH) q.push_back(m_word);
      else so = 1'b1;
    end
    if (err_at == cyc) se = 1'b1;
    if (v) begin
      if (cyc <= last_busy) so = 1'b1;
      else if (a == 2'b00) begin
        if (!rnw) begin
          m_size = data[1:0];
          m_inc = data[12:8];
        end
        last_busy = cyc + 1;
      end else if (a == 2'b10) begin
        err_at = cyc + 1;
        last_busy = cyc + 1;
      end else begin
        m_word = {data, a == 2'b11, m_size, m_inc, ~rnw};
        push_at = cyc + 2;
        last_busy = cyc + 2;
      end
    end
    m_ovf = (m_ovf && !clr) || so;
    m_err = (m_err && !clr) || se;
    cyc++;
  endtask
  task automatic compare();
    chk("rempty", 41'(bus.rempty), 41'(q.size() == 0));
    chk("level", 41'(bus.level), 41'(q.size()));
    chk("ack_wait", 41'(bus.ack_wait), 41'(q.size() == DEPTH || cyc <= last_busy));
    chk("sticky_ovf", 41'(bus.sticky_ovf), 41'(m_ovf));
    chk("sticky_err", 41'(bus.sticky_err), 41'(m_err));
    if (q.size() > 0) chk("head", bus.rdata_fifo1, q[0]);
  endtask
  task automatic tick(logic v, logic [34:0] r, logic clr, logic inc);
    bus.upd_valid = v;
    bus.upd_data = r;
    bus.sticky_clr = clr;
    bus.rinc = inc;
    @(posedge clk);
    model_edge(v, r, clr, inc);
    #1;
    compare();
    bus.upd_valid = 1'b0;
    bus.sticky_clr = 1'b0;
    bus.rinc = 1'b0;
  endtask
  task automatic idle(int n);
    repeat (n) tick(1'b0, 35'd0, 1'b0, 1'b0);
  endtask
  task automatic send(logic [31:0] d, logic [1:0] a, logic rnw);
    tick(1'b1, req(d, a, rnw), 1'b0, 1'b0);
  endtask
  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    compare();
  endtask
  initial begin
    bus.upd_valid = 1'b0;
    bus.upd_data = '0;
    bus.sticky_clr = 1'b0;
    bus.rinc = 1'b0;
    vt[0] = '{32'h0000_0102, 2'b00, 1'b0, 41'd0, 0};
    vt[1] = '{32'h2000_0000, 2'b01, 1'b0, {32'h2000_0000, 1'b0, 2'b10, 5'd1, 1'b1}, 1};
    vt[2] = '{32'h0000_0000, 2'b11, 1'b1, {32'h0000_0000, 1'b1, 2'b10, 5'd1, 1'b0}, 1};
    vt[3] = '{32'h0000_1F01, 2'b00, 1'b0, 41'd0, 0};
    vt[4] = '{32'hDEAD_BEEF, 2'b11, 1'b0, {32'hDEAD_BEEF, 1'b1, 2'b01, 5'd31, 1'b1}, 1};
    vt[5] = '{32'h0000_0003, 2'b00, 1'b1, 41'd0, 0};
    vt[6] = '{32'h1234_5678, 2'b01, 1'b1, {32'h1234_5678, 1'b0, 2'b01, 5'd31, 1'b0}, 1};
    vt[7] = '{32'h0000_FFFF, 2'b10, 1'b0, 41'd0, 0};
    do_reset(2);
    chk("rst_rdata", bus.rdata_fifo1, 41'd0);
    chk("rst_rempty", 41'(bus.rempty), 41'd1);
    chk("rst_level", 41'(bus.level), 41'd0);
    chk("rst_ack_wait", 41'(bus.ack_wait), 41'd0);
    chk("rst_ovf", 41'(bus.sticky_ovf), 41'd0);
    chk("rst_err", 41'(bus.sticky_err), 41'd0);
    for (int i = 0; i < 8; i++) begin
      send(vt[i].d, vt[i].a, vt[i].rnw);
      idle(3);
      chk($sformatf("vec%0d_level", i), 41'(bus.level), 41'(vt[i].lvl));
      if (vt[i].lvl > 0) begin
        chk($sformatf("vec%0d_word", i), bus.rdata_fifo1, vt[i].w);
        tick(1'b0, 35'd0, 1'b0, 1'b1);
        chk($sformatf("vec%0d_drained", i), 41'(bus.rempty), 41'd1);
      end
    end
    chk("vec_bad_a_err", 41'(bus.sticky_err), 41'd1);
    do_reset(1);
    send(32'h0000_0102, 2'b00, 1'b0);
    idle(3);
    send(32'h2000_0000, 2'b01, 1'b0);
    chk("lat_edge1_empty", 41'(bus.rempty), 41'd1);
    idle(1);
    chk("lat_edge2_empty", 41'(bus.rempty), 41'd1);
    idle(1);
    chk("lat_edge3_ready", 41'(bus.rempty), 41'd0);
    chk("lat_word", bus.rdata_fifo1, {32'h2000_0000, 1'b0, 2'b10, 5'd1, 1'b1});
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      send(32'h100 + i, 2'b01, 1'b0);
      idle(3);
    end
    chk("ovf_level", 41'(bus.level), 41'd4);
    chk("ovf_ack_wait", 41'(bus.ack_wait), 41'd1);
    chk("ovf_sticky", 41'(bus.sticky_ovf), 41'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_drain%0d", i), 41'(bus.rdata_fifo1[40:9]), 41'(32'h100 + i));
      tick(1'b0, 35'd0, 1'b0, 1'b1);
    end
    chk("ovf_empty", 41'(bus.rempty), 41'd1);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      send(32'h200 + i, 2'b01, 1'b0);
      idle(3);
    end
    send(32'h2FF, 2'b11, 1'b0);
    idle(1);
    tick(1'b0, 35'd0, 1'b0, 1'b1);
    chk("pp_full_level", 41'(bus.level), 41'd4);
    chk("pp_full_no_ovf", 41'(bus.sticky_ovf), 41'd0);
    repeat (3) tick(1'b0, 35'd0, 1'b0, 1'b1);
    chk("pp_tail", 41'(bus.rdata_fifo1[40:8]), 41'({32'h2FF, 1'b1}));
    do_reset(1);
    send(32'h0, 2'b10, 1'b0);
    idle(1);
    chk("err_bad_a", 41'(bus.sticky_err), 41'd1);
    chk("err_no_push", 41'(bus.level), 41'd0);
    tick(1'b0, 35'd0, 1'b1, 1'b0);
    chk("err_clr", 41'(bus.sticky_err), 41'd0);
    tick(1'b0, 35'd0, 1'b0, 1'b1);
    chk("err_empty_pop", 41'(bus.sticky_err), 41'd1);
    tick(1'b0, 35'd0, 1'b1, 1'b1);
    chk("err_set_wins", 41'(bus.sticky_err), 41'd1);
    tick(1'b0, 35'd0, 1'b1, 1'b0);
    chk("err_clr2", 41'(bus.sticky_err), 41'd0);
    send(32'h1, 2'b01, 1'b0);
    send(32'h2, 2'b01, 1'b0);
    chk("busy_ovf", 41'(bus.sticky_ovf), 41'd1);
    idle(2);
    chk("busy_one_push", 41'(bus.level), 41'd1);
    do_reset(1);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset(1);
      else tick($urandom_range(0, 3) == 0,
                req($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))),
                $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
